trx_seq_ctrl: RTL and testbench

- Transceiver sequencer; shares the single shared transmit/receive datapath between a transmit request and a receive request.
- TX path: drives the inFIFO read-enable and the msk_modulator empty input for a programmed bit count, then flushes the modulator.
- RX path: gates the decoder/cordic front end, hunts for a start-of-frame delimiter in the cdr bit stream, then writes a programmed number of payload bits into outFIFO.
- Sits beside TOP's datapath instances; replaces manual test-mux sequencing in functional mode.

---
 rtl/trx_seq_pkg.sv | 17 +
 rtl/trx_seq_ctrl_if.sv | 40 ++++
 rtl/sfd_detector.sv | 28 ++
 rtl/trx_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_trx_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trx_seq_pkg.sv
// Shared types and default constants for the transceiver sequencer.
package trx_seq_pkg;

  localparam int         LEN_W_DEFAULT        = 8;
  localparam logic [7:0] SFD_DEFAULT          = 8'hA7;
  localparam int         FLUSH_CYCLES_DEFAULT = 16;
  localparam int         SYNC_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_RUN   = 3'd1,
    TX_FLUSH = 3'd2,
    RX_SYNC  = 3'd3,
    RX_DATA  = 3'd4
  } state_t;

endpackage

// File: rtl/trx_seq_ctrl_if.sv
// Request, FIFO, modulator and cdr signals of the sequencer, grouped as one bus.
interface trx_seq_ctrl_if #(parameter int LEN_W = 8);

  logic             inTxReq;
  logic [LEN_W-1:0] inTxLen;
  logic             inRxReq;
  logic [LEN_W-1:0] inRxLen;
  logic             inAbort;
  logic             inFifoEmpty;
  logic             inCoderReady;
  logic             inCdrFlag;
  logic             inCdrData;
  logic             inOutFifoFull;
  logic             outFifoReadEnable;
  logic             outCoderEmpty;
  logic             outRxEnable;
  logic             outOutFifoWriteEnable;
  logic             outOutFifoData;
  logic             outTxDone;
  logic             outRxDone;
  logic             outErr;
  logic [2:0]       outState;

  // Sequencer side.
  modport master (
    input  inTxReq, inTxLen, inRxReq, inRxLen, inAbort, inFifoEmpty,
           inCoderReady, inCdrFlag, inCdrData, inOutFifoFull,
    output outFifoReadEnable, outCoderEmpty, outRxEnable, outOutFifoWriteEnable,
           outOutFifoData, outTxDone, outRxDone, outErr, outState
  );

  // Datapath / host side.
  modport slave (
    output inTxReq, inTxLen, inRxReq, inRxLen, inAbort, inFifoEmpty,
           inCoderReady, inCdrFlag, inCdrData, inOutFifoFull,
    input  outFifoReadEnable, outCoderEmpty, outRxEnable, outOutFifoWriteEnable,
           outOutFifoData, outTxDone, outRxDone, outErr, outState
  );

endinterface

// File: rtl/sfd_detector.sv
// Hunts for the start-of-frame delimiter in the cdr bit stream, MSB first.
module sfd_detector
  import trx_seq_pkg::*;
#(
  parameter logic [7:0] SFD = SFD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic shift,
  input  logic din,
  output logic match
);

  logic [6:0] sr;
  logic [7:0] cand;

  // The incoming bit joins the window in the same cycle it is compared.
  assign cand  = {sr, din};
  assign match = shift && (cand == SFD);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || match) sr <= '0;
    else if (shift)               sr <= cand[6:0];
  end

endmodule

// File: rtl/trx_seq_ctrl.sv
// Transceiver sequencer: arbitrates the shared TX/RX datapath and steps it through a frame.
module trx_seq_ctrl
  import trx_seq_pkg::*;
#(
  parameter int         LEN_W        = LEN_W_DEFAULT,
  parameter logic [7:0] SFD          = SFD_DEFAULT,
  parameter int         FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int         SYNC_TIMEOUT = SYNC_TIMEOUT_DEFAULT
) (
  input  logic           inClock,
  input  logic           inReset,
  trx_seq_ctrl_if.master bus
);

  localparam int CNT_W = LEN_W + 1;
  localparam int FL_W  = $clog2(FLUSH_CYCLES);
  localparam int TO_W  = $clog2(SYNC_TIMEOUT);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0] TOUT_LAST  = TO_W'(SYNC_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              last_rx;
  logic [LEN_W-1:0]  tx_len, rx_len;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic [FL_W-1:0]   flush_cnt;
  logic [TO_W-1:0]   tout_cnt;
  logic              tx_done_q, rx_done_q, wr_q, wr_data_q;

  logic grant_tx, grant_rx, rd, underflow, tx_last;
  logic rx_take, overflow, rx_last, sfd_hit, tout_hit, flush_end;

  // Ties go to the side that did not win last time.
  assign grant_tx  = (state == IDLE) && bus.inTxReq && (!bus.inRxReq || last_rx);
  assign grant_rx  = (state == IDLE) && bus.inRxReq && !grant_tx;

  assign tx_last   = (tx_cnt + CNT_W'(1)) == {1'b0, tx_len};
  assign rd        = (state == TX_RUN) && bus.inCoderReady && !bus.inFifoEmpty && !bus.inAbort;
  assign underflow = (state == TX_RUN) && bus.inCoderReady && bus.inFifoEmpty && !bus.inAbort
                     && (tx_cnt < {1'b0, tx_len});
  assign flush_end = (state == TX_FLUSH) && (flush_cnt == FLUSH_LAST) && !bus.inAbort;

  assign rx_last   = (rx_cnt + CNT_W'(1)) == {1'b0, rx_len};
  assign rx_take   = (state == RX_DATA) && bus.inCdrFlag && !bus.inAbort;
  assign overflow  = rx_take && bus.inOutFifoFull;
  assign tout_hit  = (state == RX_SYNC) && (tout_cnt == TOUT_LAST) && !sfd_hit && !bus.inAbort;

  sfd_detector #(.SFD(SFD)) u_sfd (
    .clk   (inClock),
    .rst_n (inReset),
    .clear (state != RX_SYNC),
    .shift ((state == RX_SYNC) && bus.inCdrFlag && !bus.inAbort),
    .din   (bus.inCdrData),
    .match (sfd_hit)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_tx)      state_nxt = (bus.inTxLen == '0) ? TX_FLUSH : TX_RUN;
        else if (grant_rx) state_nxt = RX_SYNC;
      end
      TX_RUN:   if (underflow || (rd && tx_last)) state_nxt = TX_FLUSH;
      TX_FLUSH: if (flush_end) state_nxt = IDLE;
      RX_SYNC: begin
        if (sfd_hit)       state_nxt = (rx_len == '0) ? IDLE : RX_DATA;
        else if (tout_hit) state_nxt = IDLE;
      end
      RX_DATA:  if (overflow || (rx_take && rx_last)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (bus.inAbort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge inClock) begin
    if (!inReset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge inClock) begin
    if (!inReset) begin
      last_rx   <= 1'b1;
      tx_len    <= '0;
      rx_len    <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      flush_cnt <= '0;
      tout_cnt  <= '0;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      wr_q      <= 1'b0;
      wr_data_q <= 1'b0;
    end else begin
      tx_done_q <= flush_end;
      rx_done_q <= 1'b0;
      wr_q      <= 1'b0;

      if (grant_tx) begin
        last_rx <= 1'b0;
        tx_len  <= bus.inTxLen;
        tx_cnt  <= '0;
      end else if (rd && tx_cnt != '1) begin
        tx_cnt  <= tx_cnt + CNT_W'(1);
      end

      flush_cnt <= (state == TX_FLUSH) ? flush_cnt + FL_W'(1) : '0;

      if (grant_rx) begin
        last_rx  <= 1'b1;
        rx_len   <= bus.inRxLen;
        rx_cnt   <= '0;
        tout_cnt <= '0;
      end else if (state == RX_SYNC && tout_cnt != TOUT_LAST) begin
        tout_cnt <= tout_cnt + TO_W'(1);
      end

      // A zero-length frame completes as soon as the delimiter is seen.
      if (sfd_hit && rx_len == '0) rx_done_q <= 1'b1;

      if (rx_take && !overflow) begin
        wr_q      <= 1'b1;
        wr_data_q <= bus.inCdrData;
        if (rx_cnt != '1) rx_cnt <= rx_cnt + CNT_W'(1);
        if (rx_last)      rx_done_q <= 1'b1;
      end
    end
  end

  assign bus.outFifoReadEnable     = rd;
  assign bus.outCoderEmpty         = (state == TX_RUN) ? bus.inFifoEmpty : 1'b1;
  assign bus.outRxEnable           = (state == RX_SYNC) || (state == RX_DATA);
  assign bus.outOutFifoWriteEnable = wr_q;
  assign bus.outOutFifoData        = wr_data_q;
  assign bus.outTxDone             = tx_done_q;
  assign bus.outRxDone             = rx_done_q;
  assign bus.outErr                = underflow || overflow || tout_hit;
  assign bus.outState              = state;

endmodule

// File: tb/tb_trx_seq_ctrl.sv
// Self-checking bench for trx_seq_ctrl: FIFO model, write scoreboard and event counters.
module tb_trx_seq_ctrl;
  import trx_seq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trx_seq_ctrl_if #(.LEN_W(8)) ifc ();

  trx_seq_ctrl #(.LEN_W(8)) dut (
    .inClock (clk),
    .inReset (rst_n),
    .bus     (ifc.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor statistics, sampled on the falling edge.
  int   rd_cnt, wr_cnt, txd_cnt, rxd_cnt, err_cnt, flush_len, sync_len;
  int   err_sync_at, err_at_ready, rxd_with_wr, ce_viol;
  int   fifo_lvl = 0;
  logic rd_seen   = 1'b0;
  logic flag_prev = 1'b0;
  bit   exp_q[$];

  always @(negedge clk) begin
    rd_seen = ifc.outFifoReadEnable;
    if (rst_n) begin
      if (ifc.outFifoReadEnable) rd_cnt++;
      if (ifc.outState == TX_RUN && ifc.outCoderEmpty !== ifc.inFifoEmpty) ce_viol++;
      if (ifc.outState == TX_FLUSH) flush_len++;
      if (ifc.outState == RX_SYNC) sync_len++;
      if (ifc.outTxDone) txd_cnt++;
      if (ifc.outRxDone) begin
        rxd_cnt++;
        if (ifc.outOutFifoWriteEnable) rxd_with_wr++;
      end
      if (ifc.outErr) begin
        err_cnt++;
        if (ifc.outState == RX_SYNC) err_sync_at = sync_len;
        if (ifc.inCoderReady) err_at_ready++;
      end
      if (ifc.outOutFifoWriteEnable) begin
        wr_cnt++;
        check("wr_after_flag", flag_prev, 1);
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("wr_data", ifc.outOutFifoData, exp_q.pop_front());
      end
    end
    flag_prev = ifc.inCdrFlag;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_seen && fifo_lvl > 0) fifo_lvl--;
    ifc.inFifoEmpty = (fifo_lvl == 0);
  endtask

  task automatic clear_stats();
    rd_cnt = 0; wr_cnt = 0; txd_cnt = 0; rxd_cnt = 0; err_cnt = 0;
    flush_len = 0; sync_len = 0; err_sync_at = 0; err_at_ready = 0;
    rxd_with_wr = 0; ce_viol = 0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (ifc.outState != IDLE && n < bound) begin
      tick();
      n++;
    end
    check(tag, n < bound, 1);
  endtask

  task automatic send_bit(input bit b, input bit payload);
    ifc.inCdrFlag = 1'b1;
    ifc.inCdrData = b;
    if (payload) exp_q.push_back(b);
    tick();
    ifc.inCdrFlag = 1'b0;
    tick();
  endtask

  task automatic send_sfd();
    logic [7:0] s = SFD_DEFAULT;
    for (int i = 7; i >= 0; i--) send_bit(s[i], 1'b0);
  endtask

  task automatic start_rx(input int len, input string tag);
    ifc.inRxLen = 8'(len);
    ifc.inRxReq = 1'b1;
    tick();
    ifc.inRxReq = 1'b0;
    check(tag, ifc.outState, RX_SYNC);
  endtask

  // TX frame with the coder consuming one bit every 8 cycles.
  task automatic run_tx(input int len, input int fifo_bits);
    fifo_lvl = fifo_bits;
    ifc.inFifoEmpty = (fifo_lvl == 0);
    ifc.inTxLen = 8'(len);
    ifc.inTxReq = 1'b1;
    tick();
    ifc.inTxReq = 1'b0;
    check("tx_grant_state", ifc.outState, TX_RUN);
    for (int i = 0; i < 300 && txd_cnt == 0; i++) begin
      ifc.inCoderReady = (i % 8 == 7);
      tick();
    end
    ifc.inCoderReady = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pre = 4'b0110;
    logic [3:0] pay = 4'b1101;

    ifc.inTxReq = 0; ifc.inTxLen = 0; ifc.inRxReq = 0; ifc.inRxLen = 0;
    ifc.inAbort = 0; ifc.inFifoEmpty = 1; ifc.inCoderReady = 0;
    ifc.inCdrFlag = 0; ifc.inCdrData = 0; ifc.inOutFifoFull = 0;
    clear_stats();
    repeat (3) tick();

    // Reset values
    check("rst_state", ifc.outState, IDLE);
    check("rst_rd", ifc.outFifoReadEnable, 0);
    check("rst_coder_empty", ifc.outCoderEmpty, 1);
    check("rst_rx_en", ifc.outRxEnable, 0);
    check("rst_wr", ifc.outOutFifoWriteEnable, 0);
    check("rst_wr_data", ifc.outOutFifoData, 0);
    check("rst_done", {ifc.outTxDone, ifc.outRxDone, ifc.outErr}, 0);
    rst_n = 1'b1;
    tick();

    // Normal TX frame
    clear_stats();
    run_tx(4, 4);
    check("tx_reads", rd_cnt, 4);
    check("tx_flush_len", flush_len, 16);
    check("tx_done", txd_cnt, 1);
    check("tx_err", err_cnt, 0);
    check("tx_coder_empty", ce_viol, 0);
    check("tx_end_state", ifc.outState, IDLE);

    // TX underflow
    clear_stats();
    run_tx(6, 3);
    check("uf_reads", rd_cnt, 3);
    check("uf_err", err_cnt, 1);
    check("uf_err_on_ready", err_at_ready, 1);
    check("uf_flush_len", flush_len, 16);
    check("uf_done", txd_cnt, 1);

    // RX frame: preamble, delimiter, 4-bit payload
    clear_stats();
    start_rx(4, "rx_grant_state");
    check("rx_enable", ifc.outRxEnable, 1);
    for (int i = 3; i >= 0; i--) send_bit(pre[i], 1'b0);
    send_sfd();
    check("rx_data_state", ifc.outState, RX_DATA);
    for (int i = 3; i >= 0; i--) send_bit(pay[i], 1'b1);
    repeat (3) tick();
    check("rx_writes", wr_cnt, 4);
    check("rx_done", rxd_cnt, 1);
    check("rx_done_with_wr", rxd_with_wr, 1);
    check("rx_err", err_cnt, 0);
    check("rx_q_drained", exp_q.size(), 0);
    check("rx_end_state", ifc.outState, IDLE);

    // Zero-length RX: done right after the delimiter, no writes
    clear_stats();
    start_rx(0, "rx0_grant_state");
    send_sfd();
    tick();
    check("rx0_done", rxd_cnt, 1);
    check("rx0_writes", wr_cnt, 0);
    check("rx0_state", ifc.outState, IDLE);

    // RX sync timeout
    clear_stats();
    start_rx(4, "to_grant_state");
    for (int i = 0; i < 1100 && err_cnt == 0; i++) begin
      ifc.inCdrFlag = (i % 4 == 0);
      ifc.inCdrData = 1'b0;
      tick();
    end
    ifc.inCdrFlag = 1'b0;
    check("to_err_cycle", err_sync_at, 1024);
    check("to_state", ifc.outState, IDLE);
    tick();
    check("to_sync_len", sync_len, 1024);
    check("to_err", err_cnt, 1);
    check("to_writes", wr_cnt, 0);

    // Arbitration with both requests held
    clear_stats();
    ifc.inTxLen = 8'd0;
    ifc.inRxLen = 8'd0;
    ifc.inTxReq = 1'b1;
    ifc.inRxReq = 1'b1;
    tick();
    check("arb_grant1_tx", ifc.outState, TX_FLUSH);
    wait_idle("arb_flush_ends", 40);
    tick();
    check("arb_grant2_rx", ifc.outState, RX_SYNC);
    ifc.inAbort = 1'b1;
    tick();
    ifc.inAbort = 1'b0;
    check("arb_abort_idle", ifc.outState, IDLE);
    tick();
    check("arb_grant3_tx", ifc.outState, TX_FLUSH);
    ifc.inTxReq = 1'b0;
    ifc.inRxReq = 1'b0;
    wait_idle("arb_flush2_ends", 40);
    tick();
    check("arb_tx_done", txd_cnt, 2);
    check("arb_rx_done", rxd_cnt, 0);

    // Abort in RX_DATA after 2 of 8 bits
    clear_stats();
    start_rx(8, "ab_grant_state");
    send_sfd();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    ifc.inAbort = 1'b1;
    tick();
    ifc.inAbort = 1'b0;
    check("ab_state", ifc.outState, IDLE);
    check("ab_rx_enable", ifc.outRxEnable, 0);
    repeat (3) tick();
    check("ab_writes", wr_cnt, 2);
    check("ab_no_done", rxd_cnt, 0);
    check("ab_no_err", err_cnt, 0);

    // outFIFO full on the 3rd payload flag
    clear_stats();
    start_rx(8, "of_grant_state");
    send_sfd();
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    ifc.inOutFifoFull = 1'b1;
    ifc.inCdrFlag = 1'b1;
    ifc.inCdrData = 1'b1;
    tick();
    ifc.inCdrFlag = 1'b0;
    ifc.inOutFifoFull = 1'b0;
    check("of_state", ifc.outState, IDLE);
    repeat (2) tick();
    check("of_err", err_cnt, 1);
    check("of_writes", wr_cnt, 2);
    check("of_no_done", rxd_cnt, 0);

    // Reset mid-frame, then a tie must go to TX again
    clear_stats();
    fifo_lvl = 4;
    ifc.inFifoEmpty = 1'b0;
    ifc.inTxLen = 8'd4;
    ifc.inTxReq = 1'b1;
    tick();
    ifc.inTxReq = 1'b0;
    check("mr_state_run", ifc.outState, TX_RUN);
    rst_n = 1'b0;
    tick();
    check("mr_state_idle", ifc.outState, IDLE);
    check("mr_coder_empty", ifc.outCoderEmpty, 1);
    rst_n = 1'b1;
    fifo_lvl = 0;
    ifc.inTxLen = 8'd0;
    ifc.inTxReq = 1'b1;
    ifc.inRxReq = 1'b1;
    tick();
    ifc.inTxReq = 1'b0;
    ifc.inRxReq = 1'b0;
    check("mr_tie_tx", ifc.outState, TX_FLUSH);
    wait_idle("mr_flush_ends", 40);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
